// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath: paddle command codes, the paddle
// speed state and the default playfield geometry also used by the renderer.
package pong_pkg;

  // Two-bit paddle command codes; 2'b11 is illegal and treated as idle.
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;

  // Paddle speed state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SLOW = 2'b01,
    FAST = 2'b10
  } paddle_state_t;

  // Default geometry and motion constants.
  localparam int POS_W_DEF       = 10;
  localparam int SCREEN_W_DEF    = 640;
  localparam int PADDLE_W_DEF    = 80;
  localparam int STEP_SLOW_DEF   = 2;
  localparam int STEP_FAST_DEF   = 6;
  localparam int ACCEL_TICKS_DEF = 4;

endpackage

// File: rtl/paddle_cmd_latch.sv
// Sticky left/right latch for one frame window. Accumulates what the button
// controller asked for between ticks and reports the window's direction
// (including the command present in the tick cycle itself).
module paddle_cmd_latch
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] paddle,
  input  logic       tick,
  output logic [1:0] win
);

  logic left_seen;
  logic right_seen;
  logic cur_left;
  logic cur_right;

  // Flags as they would stand including the current cycle's command.
  assign cur_left  = left_seen  | (paddle == CMD_LEFT);
  assign cur_right = right_seen | (paddle == CMD_RIGHT);

  // Resolve the window: exactly one direction wins, both or neither is idle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned (no latch).
    win = CMD_IDLE;
    if (cur_left && !cur_right) begin
      win = CMD_LEFT;
    end else if (cur_right && !cur_left) begin
      win = CMD_RIGHT;
    end
  end

  // Accumulate flags between ticks; a tick clears them and drops the tick-cycle command.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (!reset) begin
      left_seen  <= 1'b0;
      right_seen <= 1'b0;
    end else if (tick) begin
      left_seen  <= 1'b0;
      right_seen <= 1'b0;
    end else begin
      left_seen  <= cur_left;
      right_seen <= cur_right;
    end
  end

endmodule

// File: rtl/paddle_tracker.sv
// Per-player paddle position integrator. Once per frame tick it applies the
// window's direction with a slow/fast acceleration scheme and clamps the
// paddle's left edge to [0, SCREEN_W - PADDLE_W].
module paddle_tracker
  import pong_pkg::*;
#(
  parameter int POS_W       = POS_W_DEF,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int PADDLE_W    = PADDLE_W_DEF,
  parameter int STEP_SLOW   = STEP_SLOW_DEF,
  parameter int STEP_FAST   = STEP_FAST_DEF,
  parameter int ACCEL_TICKS = ACCEL_TICKS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       paddle,
  input  logic             tick,
  output logic [POS_W-1:0] pos,
  output logic             at_left,
  output logic             at_right,
  output logic [1:0]       moving
);

  localparam int MAX_POS = SCREEN_W - PADDLE_W;
  localparam int CNT_W   = $clog2(ACCEL_TICKS + 1);

  // Position arithmetic is one bit wider than the bus so right moves cannot wrap.
  localparam logic [POS_W:0]     MAX_X       = (POS_W+1)'(MAX_POS);
  localparam logic [POS_W:0]     STEP_SLOW_X = (POS_W+1)'(STEP_SLOW);
  localparam logic [POS_W:0]     STEP_FAST_X = (POS_W+1)'(STEP_FAST);
  localparam logic [POS_W-1:0]   RESET_POS   = POS_W'(MAX_POS / 2);
  localparam logic [CNT_W-1:0]   ACCEL_X     = CNT_W'(ACCEL_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

  paddle_state_t    state, state_n;
  logic [CNT_W-1:0] run_cnt, run_n;
  logic [1:0]       moving_n;
  logic [POS_W-1:0] pos_n;
  logic [POS_W:0]   pos_ext;
  logic [POS_W:0]   pos_calc;
  logic [POS_W:0]   step;
  logic [1:0]       win;

  paddle_cmd_latch u_latch (
    .clk    (clk),
    .reset  (reset),
    .paddle (paddle),
    .tick   (tick),
    .win    (win)
  );

  // Next speed state, run length, direction and clamped position for this tick.
  always_comb begin
    state_n  = state;
    run_n    = run_cnt;
    moving_n = moving;
    step     = '0;
    pos_ext  = {1'b0, pos};
    pos_calc = pos_ext;
    if (tick) begin
      if (win == CMD_IDLE) begin
        state_n  = IDLE;
        run_n    = '0;
        moving_n = CMD_IDLE;
      end else begin
        moving_n = win;
        if (state == IDLE || win != moving) begin
          // A fresh run always starts slow.
          state_n = SLOW;
          run_n   = CNT_ONE;
          step    = STEP_SLOW_X;
          if (CNT_ONE >= ACCEL_X) begin
            state_n = FAST;
          end
        end else if (state == SLOW) begin
          step = STEP_SLOW_X;
          if (run_cnt < ACCEL_X) begin
            run_n = run_cnt + 1'b1;
          end
          if (run_n >= ACCEL_X) begin
            state_n = FAST;
          end
        end else begin
          step = STEP_FAST_X;
        end
        // Clamp at the walls; hitting one leaves the speed state alone.
        if (win == CMD_LEFT) begin
          pos_calc = (pos_ext < step) ? '0 : pos_ext - step;
        end else begin
          pos_calc = (pos_ext + step > MAX_X) ? MAX_X : pos_ext + step;
        end
      end
    end
    pos_n = pos_calc[POS_W-1:0];
  end

  // Register state and outputs; edge flags are derived from the same next position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      run_cnt  <= '0;
      moving   <= CMD_IDLE;
      pos      <= RESET_POS;
      at_left  <= 1'b0;
      at_right <= 1'b0;
    end else begin
      state    <= state_n;
      run_cnt  <= run_n;
      moving   <= moving_n;
      pos      <= pos_n;
      at_left  <= (pos_n == '0);
      at_right <= ({1'b0, pos_n} == MAX_X);
    end
  end

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker at default parameters: a table of frame
// windows with hand-computed positions, plus hand sequences for async reset,
// wall clamping and back-to-back ticks.
module tb_paddle_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] paddle;
  logic       tick;
  logic [9:0] pos;
  logic       at_left;
  logic       at_right;
  logic [1:0] moving;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;     // pulse reset before this window
    logic [1:0] a;       // command in cycle 1 of the window
    logic [1:0] b;       // command in later odd cycles
    logic [1:0] tc;      // command in the tick cycle
    int         len;     // non-tick cycles before the tick
    int         exp_pos;
    logic [1:0] exp_mv;
  } vec_t;

  vec_t tbl[$];

  paddle_tracker dut (
    .clk      (clk),
    .reset    (reset),
    .paddle   (paddle),
    .tick     (tick),
    .pos      (pos),
    .at_left  (at_left),
    .at_right (at_right),
    .moving   (moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] p, input logic t);
    @(negedge clk);
    paddle = p;
    tick   = t;
  endtask

  task automatic check_state(input string name, input int exp_pos, input logic [1:0] exp_mv);
    check({name, " pos"}, 16'(pos), 16'(exp_pos));
    check({name, " moving"}, 16'(moving), 16'(exp_mv));
    check({name, " at_left"}, 16'(at_left), 16'(exp_pos == 0));
    check({name, " at_right"}, 16'(at_right), 16'(exp_pos == 560));
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic apply_reset(input string name);
    @(negedge clk);
    paddle = 2'b00;
    tick   = 1'b0;
    #2 reset = 1'b0;
    #1 check_state({name, " reset"}, 280, 2'b00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One frame window; leaves the bench at the negedge after the tick edge.
  task automatic window(input logic [1:0] a, input logic [1:0] b, input logic [1:0] tc, input int len);
    for (int i = 0; i < len; i++) begin
      if (i % 2 == 1) drive((i == 1) ? a : b, 1'b0);
      else            drive(2'b00, 1'b0);
    end
    drive(tc, 1'b1);
    drive(2'b00, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    paddle = 2'b00;
    tick   = 1'b0;

    //            rst   a      b      tc     len pos  mv
    tbl.push_back('{1'b0, 2'b01, 2'b01, 2'b00, 7, 278, 2'b01});  // left slow
    tbl.push_back('{1'b0, 2'b01, 2'b01, 2'b00, 7, 276, 2'b01});
    tbl.push_back('{1'b0, 2'b01, 2'b01, 2'b00, 7, 274, 2'b01});
    tbl.push_back('{1'b1, 2'b10, 2'b10, 2'b00, 7, 282, 2'b10});  // accel from 280
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 7, 284, 2'b10});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 7, 286, 2'b10});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 7, 288, 2'b10});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 7, 294, 2'b10});  // fast
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 7, 300, 2'b10});
    tbl.push_back('{1'b0, 2'b01, 2'b10, 2'b00, 7, 300, 2'b00});  // conflict
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 4, 302, 2'b10});  // restarts slow
    tbl.push_back('{1'b0, 2'b11, 2'b11, 2'b00, 4, 302, 2'b00});  // illegal only
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 4, 304, 2'b10});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 4, 306, 2'b10});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 4, 308, 2'b10});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 4, 310, 2'b10});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 4, 316, 2'b10});  // fast
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 4, 316, 2'b00});  // empty after fast
    tbl.push_back('{1'b0, 2'b10, 2'b10, 2'b00, 4, 318, 2'b10});  // slow again
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 4, 318, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b10, 4, 320, 2'b10});  // tick-cycle only
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b01, 0, 318, 2'b01});  // direction change
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 0, 318, 2'b00});  // tick cmd not carried
    tbl.push_back('{1'b1, 2'b00, 2'b00, 2'b01, 0, 278, 2'b01});  // first tick after reset
    tbl.push_back('{1'b0, 2'b10, 2'b00, 2'b00, 5, 280, 2'b10});  // single right pulse

    apply_reset("initial");

    foreach (tbl[k]) begin
      if (tbl[k].rst) apply_reset($sformatf("row%0d", k));
      window(tbl[k].a, tbl[k].b, tbl[k].tc, tbl[k].len);
      check_state($sformatf("row%0d", k), tbl[k].exp_pos, tbl[k].exp_mv);
    end

    // Mid-FAST asynchronous reset.
    apply_reset("fast_pre");
    for (int k = 0; k < 5; k++) begin
      int exp_f;
      exp_f = (k < 4) ? 282 + 2 * k : 294;
      window(2'b10, 2'b10, 2'b00, 3);
      check($sformatf("fast_run%0d pos", k), 16'(pos), 16'(exp_f));
    end
    drive(2'b10, 1'b0);
    drive(2'b00, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_state("mid_fast reset", 280, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // Left clamp from a FAST run reaching pos 4.
    window(2'b01, 2'b01, 2'b00, 3);
    check("lclamp setup1 pos", 16'(pos), 16'd278);
    window(2'b00, 2'b00, 2'b00, 3);
    window(2'b01, 2'b01, 2'b00, 3);
    check("lclamp setup2 pos", 16'(pos), 16'd276);
    window(2'b00, 2'b00, 2'b00, 3);
    for (int k = 0; k < 48; k++) begin
      int exp_l;
      exp_l = (k < 4) ? 274 - 2 * k : 268 - 6 * (k - 3);
      window(2'b01, 2'b01, 2'b00, 3);
      check($sformatf("lrun%0d pos", k), 16'(pos), 16'(exp_l));
    end
    check("lclamp at4 at_left", 16'(at_left), 16'd0);
    for (int k = 0; k < 3; k++) begin
      window(2'b01, 2'b01, 2'b00, 3);
      check_state($sformatf("lclamp%0d", k), 0, 2'b01);
    end

    // Right clamp from a FAST run reaching pos 556.
    apply_reset("rclamp");
    window(2'b10, 2'b10, 2'b00, 3);
    window(2'b00, 2'b00, 2'b00, 3);
    window(2'b10, 2'b10, 2'b00, 3);
    check("rclamp setup pos", 16'(pos), 16'd284);
    window(2'b00, 2'b00, 2'b00, 3);
    for (int k = 0; k < 48; k++) begin
      int exp_r;
      exp_r = (k < 4) ? 286 + 2 * k : 292 + 6 * (k - 3);
      window(2'b10, 2'b10, 2'b00, 3);
      check($sformatf("rrun%0d pos", k), 16'(pos), 16'(exp_r));
    end
    check("rclamp at556 at_right", 16'(at_right), 16'd0);
    for (int k = 0; k < 3; k++) begin
      window(2'b10, 2'b10, 2'b00, 3);
      check_state($sformatf("rclamp%0d", k), 560, 2'b10);
    end

    // Back-to-back ticks: each is its own window.
    drive(2'b01, 1'b1);
    drive(2'b10, 1'b1);
    check_state("b2b first", 558, 2'b01);
    drive(2'b00, 1'b0);
    check_state("b2b second", 560, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_tracker.md
# paddle_tracker

Consumer end of the paddle command interface. Takes the 2-bit `paddle` command stream produced by the per-player button controller and integrates it into a clamped horizontal paddle position, updated once per frame tick, with a slow/fast acceleration state machine. One instance per player; its `pos` output feeds the renderer and the ball-collision logic.

## Interface
- `POS_W`, 10, width of position bus
- `SCREEN_W`, 640, playfield width in pixels
- `PADDLE_W`, 80, paddle width in pixels; max position `MAX_POS = SCREEN_W - PADDLE_W`
- `STEP_SLOW`, 2, pixels per tick in SLOW
- `STEP_FAST`, 6, pixels per tick in FAST
- `ACCEL_TICKS`, 4, consecutive same-direction SLOW moves before entering FAST

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `paddle`  in  2  command: 00 idle, 01 left, 10 right, 11 illegal (treated as idle)
- `tick`  in  1  one-cycle frame strobe
- `pos`  out  POS_W  paddle left-edge x coordinate
- `at_left`  out  1  `pos == 0`
- `at_right`  out  1  `pos == MAX_POS`
- `moving`  out  2  direction applied at last tick (00/01/10)

## Operation
- The command source emits a valid code at most every other cycle and 00 in between. A sticky latch therefore accumulates `left_seen` and `right_seen` between ticks.
- Decision at `tick` uses the latched flags ORed with the current-cycle `paddle`. The flags are then cleared, and the current cycle is not carried into the next window.
- Window result:
  - LEFT if only left was seen.
  - RIGHT if only right was seen.
  - NONE if neither was seen, or if both were seen.
- States: IDLE, SLOW, FAST. `run_cnt` counts consecutive moves in the same direction and saturates at `ACCEL_TICKS`.
- Transitions at each tick:
  - NONE: go to IDLE, `run_cnt = 0`, `moving = 00`, no move.
  - Direction differs from `moving`, or state is IDLE: go to SLOW, `run_cnt = 1`, move `STEP_SLOW`.
  - Same direction while in SLOW: move `STEP_SLOW`, increment `run_cnt`. When `run_cnt` reaches `ACCEL_TICKS`, enter FAST for the next tick.
  - Same direction while in FAST: move `STEP_FAST`.
- Arithmetic is done in POS_W+1 bits.
  - Left: `pos = (pos < step) ? 0 : pos - step`.
  - Right: `pos = (pos + step > MAX_POS) ? MAX_POS : pos + step`.
  - `pos` never leaves [0, MAX_POS].
- Hitting an edge does not change state. Holding against the wall keeps FAST, with `pos` pinned.
- Reset values:
  - `pos = MAX_POS/2` (280 at defaults).
  - State IDLE, `run_cnt = 0`, flags 0.
  - `moving = 00`, `at_left = 0`, `at_right = 0`.

## Timing
- All outputs are registered.
- A command in any cycle of a window affects `pos` on the clock edge that samples `tick`, so it is visible the cycle after the tick. Latency from tick to new `pos` is 1 cycle.
- `at_left` and `at_right` are registered alongside `pos` and are coherent with it in the same cycle.
- Back-to-back ticks are legal; each tick is an independent window.
- Reset asserted mid-window or mid-move forces reset values immediately (asynchronously). Release is synchronous to `clk`.
- A tick in the first cycle after reset release evaluates only the current-cycle `paddle`.

## Structure
- Shared package `pong_pkg`:
  - Command codes `CMD_IDLE`, `CMD_LEFT`, `CMD_RIGHT`.
  - State enum `IDLE`, `SLOW`, `FAST`.
  - Default screen and paddle constants shared with the renderer.
- Sub-module `paddle_cmd_latch` holds the sticky left/right flags, the clear-on-tick logic and the current-cycle OR. It outputs the window result. The top level holds the FSM and the position datapath.

## Test plan
All scenarios use default parameters.
- Reset: assert `reset = 0` at any point. Expect `pos = 280`, `moving = 00`, `at_left = 0`, `at_right = 0`.
- Left, 3 ticks: stream 01/00 alternating, tick every 8 cycles. Expect `pos` 278, 276, 274 and `moving = 01`.
- Acceleration: right held for 6 ticks from 280. Expect `pos` 282, 284, 286, 288, then 294, 300.
- Clamp: left held in FAST starting from `pos = 4`. Expect `pos = 0` and `at_left = 1`, with no wrap on further ticks. Mirror case: right held from 556 gives 560 and `at_right = 1`.
- Conflict, illegal code and idle:
  - A window containing both 01 and 10: no move, state IDLE, next move starts at step 2.
  - A window containing only 11: no move.
  - An empty window after FAST: next move uses step 2.
- Command on the tick cycle and mid-move reset:
  - `paddle = 10` only in the tick cycle moves right by 2.
  - `reset = 0` mid-FAST gives `pos = 280` in the same cycle.
